// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: synchronizes A/B, emits registered step/direction pulses and
// counts illegal transitions. Define QUAD_FILTER_EN to add a per-channel glitch filter.
module quad_decoder #(
    parameter int FLT_LEN = 8,
    parameter int ERR_W   = 8
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iA,
    input  logic             iB,
    input  logic             iENABLE,
    input  logic             iCLR_ERR,
    output logic             oEN,
    output logic             oUP,
    output logic             oERR,
    output logic [ERR_W-1:0] oERRCNT
);

`ifdef QUAD_FILTER_EN
    localparam int STARTUP = 3 + FLT_LEN;
`else
    localparam int STARTUP = 3;
`endif
    // Sized for the filtered worst case so both builds share one counter definition.
    localparam int                 START_W    = $clog2(4 + FLT_LEN);
    localparam logic [START_W-1:0] START_LAST = START_W'(STARTUP - 1);
    localparam logic [ERR_W-1:0]   ERR_MAX    = '1;

    typedef enum logic {
        INIT,
        TRACK
    } stateT;

    stateT              state;
    stateT              nextState;
    logic [1:0]         syncA;
    logic [1:0]         syncB;
    logic [1:0]         cur;
    logic [1:0]         prev;
    logic [1:0]         nextPrev;
    logic [1:0]         delta;
    logic [START_W-1:0] startCnt;
    logic [START_W-1:0] nextStartCnt;
    logic               nextEn;
    logic               nextUp;
    logic               nextErr;
    logic [ERR_W-1:0]   nextErrCnt;

    // Position of a channel pair along the up sequence 00->01->11->10.
    function automatic logic [1:0] phaseOf(input logic [1:0] ab);
        return {ab[1], ab[1] ^ ab[0]};
    endfunction

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            syncA <= 2'b00;
            syncB <= 2'b00;
        end else begin
            syncA <= {syncA[0], iA};
            syncB <= {syncB[0], iB};
        end
    end

`ifdef QUAD_FILTER_EN
    localparam logic [7:0] FLT_LAST = 8'(FLT_LEN - 1);

    logic       filtA;
    logic       filtB;
    logic [7:0] cntA;
    logic [7:0] cntB;

    // A channel only follows its sync value after FLT_LEN consecutive cycles of disagreement.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            filtA <= 1'b0;
            filtB <= 1'b0;
            cntA  <= 8'd0;
            cntB  <= 8'd0;
        end else begin
            if (syncA[1] != filtA) begin
                if (cntA == FLT_LAST) begin
                    filtA <= syncA[1];
                    cntA  <= 8'd0;
                end else begin
                    cntA <= cntA + 8'd1;
                end
            end else begin
                cntA <= 8'd0;
            end
            if (syncB[1] != filtB) begin
                if (cntB == FLT_LAST) begin
                    filtB <= syncB[1];
                    cntB  <= 8'd0;
                end else begin
                    cntB <= cntB + 8'd1;
                end
            end else begin
                cntB <= 8'd0;
            end
        end
    end

    assign cur = {filtA, filtB};
`else
    assign cur = {syncA[1], syncB[1]};
`endif

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state    <= INIT;
            prev     <= 2'b00;
            startCnt <= '0;
            oEN      <= 1'b0;
            oUP      <= 1'b1;
            oERR     <= 1'b0;
            oERRCNT  <= '0;
        end else begin
            state    <= nextState;
            prev     <= nextPrev;
            startCnt <= nextStartCnt;
            oEN      <= nextEn;
            oUP      <= nextUp;
            oERR     <= nextErr;
            oERRCNT  <= nextErrCnt;
        end
    end

    // INIT waits for the synchronizer/filter pipeline to fill before trusting cur,
    // so whatever the encoder rests at is adopted silently as the starting point.
    always_comb begin
        nextState    = state;
        nextPrev     = prev;
        nextStartCnt = startCnt;
        nextEn       = 1'b0;
        nextUp       = oUP;
        nextErr      = 1'b0;
        nextErrCnt   = oERRCNT;
        delta        = phaseOf(cur) - phaseOf(prev);

        case (state)
            INIT: begin
                if (startCnt == START_LAST) begin
                    nextPrev  = cur;
                    nextState = TRACK;
                end else begin
                    nextStartCnt = startCnt + START_W'(1);
                end
            end
            TRACK: begin
                nextPrev = cur;
                case (delta)
                    2'd1: begin
                        nextEn = iENABLE;
                        nextUp = 1'b1;
                    end
                    2'd3: begin
                        nextEn = iENABLE;
                        nextUp = 1'b0;
                    end
                    2'd2:    nextErr = 1'b1;
                    default: ;
                endcase
            end
            default: nextState = INIT;
        endcase

        if (nextErr && (oERRCNT != ERR_MAX)) begin
            nextErrCnt = oERRCNT + ERR_W'(1);
        end
        if (iCLR_ERR) begin
            nextErrCnt = '0;
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: directed scenarios plus a random encoder walk,
// compared every cycle against a position-based reference model.
module tb_quad_decoder;
    localparam int FLT_LEN = 8;
    localparam int ERR_W   = 2;
    localparam int ERR_MAX = (1 << ERR_W) - 1;
`ifdef QUAD_FILTER_EN
    localparam int STARTUP = 3 + FLT_LEN;
`else
    localparam int STARTUP = 3;
`endif

    logic             iCLK = 1'b0;
    logic             iRESET;
    logic             iA;
    logic             iB;
    logic             iENABLE;
    logic             iCLR_ERR;
    logic             oEN;
    logic             oUP;
    logic             oERR;
    logic [ERR_W-1:0] oERRCNT;

    int vectors     = 0;
    int miscompares = 0;
    int enSeen      = 0;
    int errSeen     = 0;

    // Position along the up sequence, indexed by {A,B}; and its inverse.
    int         seqPos[4] = '{0, 1, 3, 2};
    logic [1:0] posToAb[4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    logic [1:0] mS1;
    logic [1:0] mS2;
    logic [1:0] mPrev;
    bit         mInit;
    int         mInitEdges;
    logic       expEn;
    logic       expUp;
    logic       expErr;
    int         expCnt;
`ifdef QUAD_FILTER_EN
    logic [1:0] mFilt;
    int         mRun[2];
`endif

    quad_decoder #(.FLT_LEN(FLT_LEN), .ERR_W(ERR_W)) dut (
        .iCLK    (iCLK),
        .iRESET  (iRESET),
        .iA      (iA),
        .iB      (iB),
        .iENABLE (iENABLE),
        .iCLR_ERR(iCLR_ERR),
        .oEN     (oEN),
        .oUP     (oUP),
        .oERR    (oERR),
        .oERRCNT (oERRCNT)
    );

    always #5 iCLK = ~iCLK;

    function automatic logic [1:0] modelCur();
`ifdef QUAD_FILTER_EN
        return mFilt;
`else
        return mS2;
`endif
    endfunction

    task automatic modelReset();
        mS1        = 2'b00;
        mS2        = 2'b00;
        mPrev      = 2'b00;
        mInit      = 1'b1;
        mInitEdges = 0;
        expEn      = 1'b0;
        expUp      = 1'b1;
        expErr     = 1'b0;
        expCnt     = 0;
`ifdef QUAD_FILTER_EN
        mFilt  = 2'b00;
        mRun[0] = 0;
        mRun[1] = 0;
`endif
    endtask

    task automatic modelEdge();
        logic [1:0] cur;
        int         d;
        cur    = modelCur();
        expEn  = 1'b0;
        expErr = 1'b0;
        if (mInit) begin
            if (mInitEdges == STARTUP - 1) begin
                mPrev = cur;
                mInit = 1'b0;
            end else begin
                mInitEdges++;
            end
        end else begin
            d = (seqPos[cur] - seqPos[mPrev] + 4) % 4;
            if (d == 1) begin
                expEn = iENABLE;
                expUp = 1'b1;
            end else if (d == 3) begin
                expEn = iENABLE;
                expUp = 1'b0;
            end else if (d == 2) begin
                expErr = 1'b1;
                if (expCnt < ERR_MAX) expCnt++;
            end
            mPrev = cur;
        end
        if (iCLR_ERR) expCnt = 0;
`ifdef QUAD_FILTER_EN
        for (int i = 0; i < 2; i++) begin
            if (mS2[i] != mFilt[i]) begin
                mRun[i]++;
                if (mRun[i] == FLT_LEN) begin
                    mFilt[i] = mS2[i];
                    mRun[i]  = 0;
                end
            end else begin
                mRun[i] = 0;
            end
        end
`endif
        mS2 = mS1;
        mS1 = {iA, iB};
    endtask

    task automatic checkOutput(input string tag);
        logic [ERR_W+2:0] obsVec;
        logic [ERR_W+2:0] expVec;
        obsVec = {oEN, oUP, oERR, oERRCNT};
        expVec = {expEn, expUp, expErr, ERR_W'(expCnt)};
        vectors++;
        enSeen  += int'(oEN);
        errSeen += int'(oERR);
        assert (obsVec === expVec) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed en/up/err/cnt=%b expected %b", tag, obsVec, expVec);
        end
    endtask

    task automatic checkCount(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] ab, input logic en, input logic clr,
                                 input int n, input string tag);
        iA       = ab[1];
        iB       = ab[0];
        iENABLE  = en;
        iCLR_ERR = clr;
        repeat (n) begin
            @(posedge iCLK);
            if (!iRESET) modelEdge();
            #1;
            checkOutput(tag);
        end
    endtask

    task automatic doReset(input logic [1:0] ab);
        iA       = ab[1];
        iB       = ab[0];
        iENABLE  = 1'b1;
        iCLR_ERR = 1'b0;
        iRESET   = 1'b1;
        #1;
        modelReset();
        checkOutput("resetAsync");
        @(posedge iCLK);
        #1;
        checkOutput("resetHold");
        iRESET = 1'b0;
    endtask

    initial begin
        int         baseEn;
        int         baseErr;
        int         latency;
        logic [1:0] curAb;
        logic [1:0] nextAb;
        int         kind;

        iRESET   = 1'b0;
        iA       = 1'b0;
        iB       = 1'b0;
        iENABLE  = 1'b1;
        iCLR_ERR = 1'b0;
        #2;

        // Encoder resting at 11 through reset release stays silent.
        doReset(2'b11);
        baseEn  = enSeen;
        baseErr = errSeen;
        applyStimulus(2'b11, 1'b1, 1'b0, 20, "restAt11");
        checkCount("restNoEn", enSeen - baseEn, 0);
        checkCount("restNoErr", errSeen - baseErr, 0);

        // Eight up steps then three down steps.
        doReset(2'b00);
        applyStimulus(2'b00, 1'b1, 1'b0, 10, "settle00");
        baseEn = enSeen;
        for (int i = 0; i < 8; i++) applyStimulus(posToAb[(i + 1) % 4], 1'b1, 1'b0, 5, "upStep");
        checkCount("upPulses", enSeen - baseEn, 8);
        checkCount("upLevel", int'(oUP), 1);
        baseEn = enSeen;
        applyStimulus(2'b10, 1'b1, 1'b0, 5, "downStep");
        applyStimulus(2'b11, 1'b1, 1'b0, 5, "downStep");
        applyStimulus(2'b01, 1'b1, 1'b0, 5, "downStep");
        checkCount("downPulses", enSeen - baseEn, 3);
        checkCount("downLevel", int'(oUP), 0);

        // Illegal transitions, saturation, clear racing an error.
        baseEn  = enSeen;
        baseErr = errSeen;
        applyStimulus(2'b10, 1'b1, 1'b0, 5, "illegal");
        checkCount("errPulse", errSeen - baseErr, 1);
        checkCount("errNoEn", enSeen - baseEn, 0);
        checkCount("errCnt1", int'(oERRCNT), 1);
        applyStimulus(2'b01, 1'b1, 1'b0, 5, "illegal");
        applyStimulus(2'b10, 1'b1, 1'b0, 5, "illegal");
        applyStimulus(2'b01, 1'b1, 1'b0, 5, "illegal");
        applyStimulus(2'b10, 1'b1, 1'b0, 5, "illegal");
        checkCount("errSat", int'(oERRCNT), ERR_MAX);
        applyStimulus(2'b01, 1'b1, 1'b0, 2, "clrRace");
        applyStimulus(2'b01, 1'b1, 1'b1, 1, "clrRace");
        checkCount("clrRaceErr", int'(oERR), 1);
        checkCount("clrRaceCnt", int'(oERRCNT), 0);
        applyStimulus(2'b01, 1'b1, 1'b0, 3, "clrRace");

        // Disabled steps leave no backlog.
        baseEn = enSeen;
        applyStimulus(2'b11, 1'b0, 1'b0, 5, "disabled");
        applyStimulus(2'b10, 1'b0, 1'b0, 5, "disabled");
        applyStimulus(2'b00, 1'b0, 1'b0, 5, "disabled");
        applyStimulus(2'b01, 1'b0, 1'b0, 5, "disabled");
        applyStimulus(2'b01, 1'b1, 1'b0, 5, "reEnabled");
        checkCount("enGated", enSeen - baseEn, 0);
        applyStimulus(2'b11, 1'b1, 1'b0, 5, "reEnabled");
        checkCount("enResume", enSeen - baseEn, 1);

        // Reset shortly after a step's sync edge aborts the pulse.
        applyStimulus(2'b01, 1'b1, 1'b0, 5, "preReset");
        baseEn = enSeen;
        applyStimulus(2'b00, 1'b1, 1'b0, 2, "preReset");
        doReset(2'b00);
        applyStimulus(2'b00, 1'b1, 1'b0, 20, "postReset");
        checkCount("abortNoEn", enSeen - baseEn, 0);
        checkCount("abortUp", int'(oUP), 1);
        checkCount("abortCnt", int'(oERRCNT), 0);

        // Five-cycle glitch on A.
        baseEn = enSeen;
        applyStimulus(2'b10, 1'b1, 1'b0, 5, "glitch");
        applyStimulus(2'b00, 1'b1, 1'b0, 20, "glitchEnd");
`ifdef QUAD_FILTER_EN
        checkCount("glitchFiltered", enSeen - baseEn, 0);
`else
        checkCount("glitchRaw", enSeen - baseEn, 2);
`endif

        // Step latency measured from the sampling edge.
        latency = -1;
        baseEn  = enSeen;
        for (int i = 1; i <= 40; i++) begin
            applyStimulus(2'b01, 1'b1, 1'b0, 1, "latency");
            if (latency < 0 && enSeen != baseEn) latency = i;
        end
        checkCount("stepLatency", latency, STARTUP);
        checkCount("stepOnce", enSeen - baseEn, 1);

        // Random encoder walk with occasional illegal jumps, disables and clears.
        curAb = 2'b01;
        for (int i = 0; i < 300; i++) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 4)      nextAb = posToAb[(seqPos[curAb] + 1) % 4];
            else if (kind < 7) nextAb = posToAb[(seqPos[curAb] + 3) % 4];
            else if (kind < 9) nextAb = curAb;
            else               nextAb = curAb ^ 2'b11;
            applyStimulus(nextAb, ($urandom_range(0, 4) != 0), ($urandom_range(0, 19) == 0),
                          int'($urandom_range(1, 6)), "random");
            curAb = nextAb;
        end

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter FLT_LEN, default 8, glitch-filter stability length in cycles, legal range 1..255; used only when QUAD_FILTER_EN is defined.
REQ-002 Parameter ERR_W, default 8, width of the error counter.
REQ-003 iCLK  input  1  clock; all state changes on its rising edge.
REQ-004 iRESET  input  1  reset, asynchronous, active-high.
REQ-005 iA, iB  input  1 each  raw quadrature channels, asynchronous to iCLK.
REQ-006 iENABLE  input  1  when 0, step pulses are suppressed.
REQ-007 iCLR_ERR  input  1  synchronous clear of oERRCNT.
REQ-008 oEN  output  1  one-cycle step pulse; drives the counter's count enable.
REQ-009 oUP  output  1  direction level, 1 = up; drives the counter's up/down input.
REQ-010 oERR  output  1  one-cycle pulse on an illegal transition.
REQ-011 oERRCNT  output  ERR_W  saturating count of illegal transitions.

Function
REQ-012 Each of iA and iB SHALL pass through a 2-flop synchronizer; the second flop output is the channel's "sync" value.
REQ-013 The "current" state cur = {A,B} SHALL be the sync values, or the filtered values when QUAD_FILTER_EN is defined.
REQ-014 The FSM SHALL have two states, INIT and TRACK, and SHALL enter INIT on reset.
REQ-015 INIT SHALL last STARTUP cycles after reset release, where STARTUP = 3, or 3+FLT_LEN with the filter; on exit it loads prev <= cur, emits no pulses and moves to TRACK.
REQ-016 In TRACK, every cycle, cur SHALL be compared with prev and prev SHALL be updated to cur.
REQ-017 Up sequence 00->01->11->10->00: oEN=1 and oUP=1 in the following cycle.
REQ-018 Down sequence (reverse order): oEN=1 and oUP=0 in the following cycle.
REQ-019 cur == prev: oEN=0, oERR=0, and oUP holds its value.
REQ-020 Both bits change (00<->11 or 01<->10): oERR=1 for one cycle, oEN=0, oUP unchanged, and oERRCNT increments.
REQ-021 oEN, oUP and oERR SHALL be registered outputs.
REQ-022 Latency without the filter: oEN asserts after the third rising edge counted from the edge that first samples the new iA/iB level.
REQ-023 With the filter, the oEN latency is the no-filter latency plus FLT_LEN cycles.
REQ-024 iENABLE=0 forces oEN=0; prev keeps tracking, so no backlog step is emitted when iENABLE returns to 1.
REQ-025 iENABLE does not gate oERR or oERRCNT.
REQ-026 oERRCNT SHALL saturate at 2**ERR_W-1 with no wrap; oERR still pulses while saturated.
REQ-027 iCLR_ERR sets oERRCNT to 0 on the next edge; if an error occurs in the same cycle, the clear wins and the count becomes 0.
REQ-028 oEN and oERR SHALL never be 1 in the same cycle.

Reset
REQ-029 While iRESET=1, all outputs and state SHALL take their reset values: synchronizer and filter flops 0, filter counters 0, prev=00, FSM=INIT, oEN=0, oUP=1, oERR=0, oERRCNT=0.
REQ-030 Reset asserted mid-sequence SHALL abort any pending pulse.
REQ-031 After reset release the block SHALL re-run INIT, so an encoder resting at any state produces no oEN and no oERR.

Configuration
REQ-032 Macro QUAD_FILTER_EN, when defined, SHALL add a per-channel filter: a channel's filtered value takes its sync value only after sync has differed from the filtered value for FLT_LEN consecutive cycles; any return to equality resets that channel's counter to 0.
REQ-033 When QUAD_FILTER_EN is undefined, no filter logic or counters are present, cur = sync, STARTUP = 3, and FLT_LEN is ignored.

Verification
REQ-034 No filter, reset released with iA=1, iB=1 held -> no oEN and no oERR for 20 cycles.
REQ-035 No filter, 8 up steps (00,01,11,10,...) held 5 cycles each -> exactly 8 oEN pulses with oUP=1; then 3 reverse steps -> 3 oEN pulses with oUP=0.
REQ-036 Step 00->11 -> one oERR pulse, oEN=0, oERRCNT=1; with ERR_W=2, 5 illegal steps -> oERRCNT=3; iCLR_ERR coincident with an error -> oERRCNT=0.
REQ-037 iENABLE=0 during 4 up steps, then iENABLE=1 -> no oEN pulses; the next up step gives exactly 1 oEN pulse.
REQ-038 QUAD_FILTER_EN, FLT_LEN=8: 5-cycle glitch on iA -> no oEN; 8-cycle stable step -> 1 oEN pulse, 8 cycles later than the no-filter build.
REQ-039 iRESET pulsed 1 cycle after a step's sync edge -> no oEN pulse; oUP=1 and oERRCNT=0 after reset.
